conv_dw_window_streamer: RTL and testbench

- Transmit-side feeder for the depthwise-separable 2D convolution datapath.
- Reads one single-channel activation tile and one KxK kernel from two 1-cycle-latency SRAM read ports.
- Emits one (activation, weight) tap pair per beat on a valid/ready stream, window by window in raster order, feeding the conv core's input_data/weight_data/valid_in port.
- Stride 1, dilation 1; no padding unless the optional feature is compiled in.

---
 rtl/conv_ds_pkg.sv | 19 +
 rtl/conv_dw_window_streamer_if.sv | 21 ++
 rtl/conv_tap_fifo2.sv | 57 +++++
 rtl/conv_dw_window_streamer.sv | 208 ++++++++++++++++++++
 tb/tb_conv_dw_window_streamer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_ds_pkg.sv
// Shared types for the depthwise conv feeder: default word width, tap beat and FSM state.
package conv_ds_pkg;

  localparam int DS_DATA_W = 32;

  typedef struct packed {
    logic [DS_DATA_W-1:0] data;
    logic [DS_DATA_W-1:0] weight;
    logic                 last_tap;
    logic                 last_window;
  } tap_beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/conv_dw_window_streamer_if.sv
// Tap stream from the window streamer to the conv core (valid/ready with window flags).
interface conv_dw_window_streamer_if #(
  parameter int DATA_W = 32
);
  logic              valid_out;
  logic              ready_in;
  logic [DATA_W-1:0] input_data;
  logic [DATA_W-1:0] weight_data;
  logic              last_tap;
  logic              last_window;

  modport master (
    output valid_out, input_data, weight_data, last_tap, last_window,
    input  ready_in
  );

  modport slave (
    input  valid_out, input_data, weight_data, last_tap, last_window,
    output ready_in
  );
endinterface

// File: rtl/conv_tap_fifo2.sv
// Two-entry synchronous FIFO for returned tap beats; simultaneous push/pop when full is allowed.
module conv_tap_fifo2
  import conv_ds_pkg::*;
#(
  parameter type T = tap_beat_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  T           wdata_i,
  input  logic       pop_i,
  output T           rdata_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);

  T           mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign count_o = count_q;

endmodule

// File: rtl/conv_dw_window_streamer.sv
// Walks KxK windows over an activation tile and streams (activation, weight) tap pairs.
// Define CONV_DW_PAD_EN for zero padding of K/2 (same-size output).
module conv_dw_window_streamer
  import conv_ds_pkg::*;
#(
  parameter int DATA_W = DS_DATA_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int K      = 3,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  input  logic [DATA_W-1:0] act_rd_data,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_rd_addr,
  input  logic [DATA_W-1:0] wgt_rd_data,
  conv_dw_window_streamer_if.master strm
);

`ifdef CONV_DW_PAD_EN
  localparam int P  = K / 2;
  localparam int OW = IMG_W;
  localparam int OH = IMG_H;
`else
  localparam int OW = IMG_W - K + 1;
  localparam int OH = IMG_H - K + 1;
`endif

  localparam logic [ADDR_W-1:0] KM1  = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] OWM1 = ADDR_W'(OW - 1);
  localparam logic [ADDR_W-1:0] OHM1 = ADDR_W'(OH - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] weight;
    logic              last_tap;
    logic              last_window;
  } beat_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
  logic              done_q, done_d;
  logic              rd_vld_q, rd_lt_q, rd_lw_q;
  logic              issue, pop, slot_ok, tap_last, win_last;
  logic              fifo_full, fifo_empty;
  logic [1:0]        fifo_count;
  beat_t             push_beat, head;

  // A slot is free unless FIFO plus in-flight read already hold two beats; a same-cycle pop frees one.
  assign pop      = !fifo_empty && strm.ready_in;
  assign slot_ok  = (fifo_full || (fifo_count == 2'd1 && rd_vld_q)) ? pop : 1'b1;
  assign issue    = (state_q == RUN) && slot_ok;
  assign tap_last = (kx_q == KM1) && (ky_q == KM1);
  assign win_last = (ox_q == OWM1) && (oy_q == OHM1);

`ifdef CONV_DW_PAD_EN
  localparam int SW = ADDR_W + 2;
  localparam logic signed [SW-1:0] PS = SW'(P);
  localparam logic signed [SW-1:0] HS = SW'(IMG_H);
  localparam logic signed [SW-1:0] WS = SW'(IMG_W);

  logic signed [SW-1:0] ay, ax;
  logic                 act_inb;
  logic                 rd_zero_q;

  assign ay      = $signed({2'b00, oy_q}) + $signed({2'b00, ky_q}) - PS;
  assign ax      = $signed({2'b00, ox_q}) + $signed({2'b00, kx_q}) - PS;
  assign act_inb = !ay[SW-1] && (ay < HS) && !ax[SW-1] && (ax < WS);

  assign act_rd_en   = issue && act_inb;
  assign act_rd_addr = act_inb ? (ay[ADDR_W-1:0] * ADDR_W'(IMG_W) + ax[ADDR_W-1:0]) : '0;
`else
  assign act_rd_en   = issue;
  assign act_rd_addr = (oy_q + ky_q) * ADDR_W'(IMG_W) + ox_q + kx_q;
`endif

  assign wgt_rd_en   = issue;
  assign wgt_rd_addr = ky_q * ADDR_W'(K) + kx_q;

  always_comb begin
    state_d = state_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          kx_d    = '0;
          ky_d    = '0;
          ox_d    = '0;
          oy_d    = '0;
        end
      end
      RUN: begin
        if (issue) begin
          if (kx_q != KM1) begin
            kx_d = kx_q + ONE;
          end else begin
            kx_d = '0;
            if (ky_q != KM1) begin
              ky_d = ky_q + ONE;
            end else begin
              ky_d = '0;
              if (ox_q != OWM1) begin
                ox_d = ox_q + ONE;
              end else begin
                ox_d = '0;
                if (oy_q != OHM1) begin
                  oy_d = oy_q + ONE;
                end else begin
                  oy_d    = '0;
                  state_d = DRAIN;
                end
              end
            end
          end
        end
      end
      DRAIN: begin
        if (fifo_empty && !rd_vld_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      kx_q     <= '0;
      ky_q     <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_lt_q  <= 1'b0;
      rd_lw_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      kx_q     <= kx_d;
      ky_q     <= ky_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      done_q   <= done_d;
      rd_vld_q <= issue;
      rd_lt_q  <= tap_last;
      rd_lw_q  <= win_last;
    end
  end

`ifdef CONV_DW_PAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_zero_q <= 1'b0;
    end else begin
      rd_zero_q <= !act_inb;
    end
  end
`endif

  // SRAM data lands one cycle after issue and is pushed together with the flags captured at issue.
  always_comb begin
    push_beat.data        = act_rd_data;
`ifdef CONV_DW_PAD_EN
    if (rd_zero_q) begin
      push_beat.data = '0;
    end
`endif
    push_beat.weight      = wgt_rd_data;
    push_beat.last_tap    = rd_lt_q;
    push_beat.last_window = rd_lw_q;
  end

  conv_tap_fifo2 #(
    .T (beat_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rd_vld_q),
    .wdata_i (push_beat),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign strm.valid_out   = !fifo_empty;
  assign strm.input_data  = head.data;
  assign strm.weight_data = head.weight;
  assign strm.last_tap    = head.last_tap;
  assign strm.last_window = head.last_window;

endmodule

// File: tb/tb_conv_dw_window_streamer.sv
// Directed bench for conv_dw_window_streamer on a 4x4 tile with a 3x3 kernel (padded build via CONV_DW_PAD_EN).
module tb_conv_dw_window_streamer;

  localparam int DW = 32;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int KK = 3;
  localparam int AW = 8;
`ifdef CONV_DW_PAD_EN
  localparam int P  = 1;
  localparam int OW = IW;
  localparam int OH = IH;
`else
  localparam int P  = 0;
  localparam int OW = IW - KK + 1;
  localparam int OH = IH - KK + 1;
`endif
  localparam int NB = OW * OH * KK * KK;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic          act_rd_en, wgt_rd_en;
  logic [AW-1:0] act_rd_addr, wgt_rd_addr;
  logic [DW-1:0] act_rd_data = '0;
  logic [DW-1:0] wgt_rd_data = '0;

  conv_dw_window_streamer_if #(.DATA_W(DW)) strm ();

  conv_dw_window_streamer #(
    .DATA_W (DW), .IMG_W (IW), .IMG_H (IH), .K (KK), .ADDR_W (AW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .act_rd_en   (act_rd_en),
    .act_rd_addr (act_rd_addr),
    .act_rd_data (act_rd_data),
    .wgt_rd_en   (wgt_rd_en),
    .wgt_rd_addr (wgt_rd_addr),
    .wgt_rd_data (wgt_rd_data),
    .strm        (strm)
  );

  always #5 clk = ~clk;

  // act[i] = i, wgt[j] = 100 + j, both with one cycle of read latency
  always @(posedge clk) begin
    if (act_rd_en) act_rd_data <= DW'(act_rd_addr);
    if (wgt_rd_en) wgt_rd_data <= DW'(100 + int'(wgt_rd_addr));
  end

  int total = 0;
  int bad   = 0;

  int exp_d [NB];
  int exp_w [NB];
  bit exp_lt [NB];
  bit exp_lw [NB];
  int exp_act_reads = 0;

  int got_d [$];
  int got_w [$];
  bit got_lt [$];
  bit got_lw [$];
  int got_cyc [$];
  int cyc = 0;
  int done_cnt = 0;
  int act_rd_cnt = 0;
  int wgt_rd_cnt = 0;
  int stall_err = 0;
  int first_act_addr = -1;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_d, prev_w;
  logic prev_lt, prev_lw;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (done) done_cnt++;
      if (act_rd_en) begin
        act_rd_cnt++;
        if (first_act_addr < 0) first_act_addr = int'(act_rd_addr);
      end
      if (wgt_rd_en) wgt_rd_cnt++;
      if (prev_stall && !(strm.valid_out && strm.input_data === prev_d && strm.weight_data === prev_w &&
                          strm.last_tap === prev_lt && strm.last_window === prev_lw))
        stall_err++;
      if (strm.valid_out && strm.ready_in) begin
        got_d.push_back(int'(strm.input_data));
        got_w.push_back(int'(strm.weight_data));
        got_lt.push_back(strm.last_tap);
        got_lw.push_back(strm.last_window);
        got_cyc.push_back(cyc);
      end
      prev_stall = strm.valid_out && !strm.ready_in;
      prev_d  = strm.input_data;
      prev_w  = strm.weight_data;
      prev_lt = strm.last_tap;
      prev_lw = strm.last_window;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_d.delete(); got_w.delete(); got_lt.delete(); got_lw.delete(); got_cyc.delete();
    done_cnt = 0; act_rd_cnt = 0; wgt_rd_cnt = 0; stall_err = 0; first_act_addr = -1;
    prev_stall = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready high one cycle in three
  task automatic run_pass(input int mode, input int budget, output bit finished);
    int n;
    n = 0;
    finished = 1'b0;
    while (n < budget && !finished) begin
      if (mode == 1) strm.ready_in = (n % 3 == 2);
      else           strm.ready_in = 1'b1;
      tick();
      n++;
      if (done) finished = 1'b1;
    end
    strm.ready_in = 1'b1;
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_beats"}, got_d.size(), NB);
    for (int i = 0; i < NB && i < got_d.size(); i++) begin
      chk($sformatf("%s_act%0d", tag, i), got_d[i], exp_d[i]);
      chk($sformatf("%s_wgt%0d", tag, i), got_w[i], exp_w[i]);
      chk($sformatf("%s_lt%0d", tag, i), got_lt[i], exp_lt[i]);
      chk($sformatf("%s_lw%0d", tag, i), got_lw[i], exp_lw[i]);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fin;
    int n;
    int b;
    int lt_n;
    int lw_n;
`ifdef CONV_DW_PAD_EN
    int win0 [9] = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
`else
    int win0 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
`endif

    b = 0;
    for (int oy = 0; oy < OH; oy++)
      for (int ox = 0; ox < OW; ox++)
        for (int ky = 0; ky < KK; ky++)
          for (int kx = 0; kx < KK; kx++) begin
            int ay, ax;
            bit inb;
            ay  = oy + ky - P;
            ax  = ox + kx - P;
            inb = (ay >= 0) && (ay < IH) && (ax >= 0) && (ax < IW);
            exp_d[b]  = inb ? ay * IW + ax : 0;
            exp_w[b]  = 100 + ky * KK + kx;
            exp_lt[b] = (kx == KK - 1) && (ky == KK - 1);
            exp_lw[b] = (ox == OW - 1) && (oy == OH - 1);
            if (inb) exp_act_reads++;
            b++;
          end

    // reset state
    strm.ready_in = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", strm.valid_out, 0);
    chk("rst_act_en", act_rd_en, 0);
    chk("rst_wgt_en", wgt_rd_en, 0);
    chk("rst_act_addr", act_rd_addr, 0);
    chk("rst_wgt_addr", wgt_rd_addr, 0);
    chk("rst_data", strm.input_data, 0);
    chk("rst_weight", strm.weight_data, 0);
    chk("rst_lt", strm.last_tap, 0);
    chk("rst_lw", strm.last_window, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // full-rate pass with first-beat latency
    clear_mon();
    pulse_start();
    chk("lat_busy", busy, 1);
    chk("lat_wgt_en", wgt_rd_en, 1);
    chk("lat_act_en", act_rd_en, (P == 0));
    chk("lat_valid1", strm.valid_out, 0);
    tick();
    chk("lat_valid2", strm.valid_out, 0);
    tick();
    chk("lat_valid3", strm.valid_out, 1);
    chk("lat_first_data", strm.input_data, exp_d[0]);
    run_pass(0, 2000, fin);
    chk("t1_done_seen", fin, 1);
    repeat (3) tick();
    check_beats("t1");
    for (int i = 0; i < 9 && i < got_d.size(); i++)
      chk($sformatf("t1_win0_%0d", i), got_d[i], win0[i]);
    if (got_cyc.size() == NB) chk("t1_consecutive", got_cyc[NB-1] - got_cyc[0], NB - 1);
    else                      chk("t1_consecutive_size", got_cyc.size(), NB);
    lt_n = 0;
    lw_n = 0;
    foreach (got_lt[i]) lt_n += int'(got_lt[i]);
    foreach (got_lw[i]) lw_n += int'(got_lw[i]);
    chk("t1_lt_count", lt_n, OW * OH);
    chk("t1_lw_count", lw_n, KK * KK);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_act_reads", act_rd_cnt, exp_act_reads);
    chk("t1_wgt_reads", wgt_rd_cnt, NB);
    chk("t1_first_act_addr", first_act_addr, 0);
    chk("t1_busy_end", busy, 0);

    // one-in-three ready duty
    clear_mon();
    strm.ready_in = 1'b0;
    pulse_start();
    run_pass(1, 4000, fin);
    chk("t2_done_seen", fin, 1);
    repeat (3) tick();
    check_beats("t2");
    chk("t2_stall_stable", stall_err, 0);
    chk("t2_done_cnt", done_cnt, 1);

    // long stall right after the first valid beat
    clear_mon();
    strm.ready_in = 1'b0;
    pulse_start();
    n = 0;
    while (!strm.valid_out && n < 10) begin
      tick();
      n++;
    end
    chk("t3_valid_seen", strm.valid_out, 1);
    repeat (20) tick();
    chk("t3_reads_while_full", wgt_rd_cnt, 2);
    chk("t3_valid_held", strm.valid_out, 1);
    chk("t3_data_held", strm.input_data, exp_d[0]);
    chk("t3_weight_held", strm.weight_data, exp_w[0]);
    chk("t3_busy", busy, 1);
    run_pass(0, 2000, fin);
    chk("t3_done_seen", fin, 1);
    repeat (3) tick();
    check_beats("t3");
    chk("t3_stall_stable", stall_err, 0);
    chk("t3_done_cnt", done_cnt, 1);

    // reset in the middle of a pass
    clear_mon();
    strm.ready_in = 1'b1;
    pulse_start();
    n = 0;
    while (got_d.size() < 15 && n < 200) begin
      tick();
      n++;
    end
    chk("t4_reached_beat15", got_d.size(), 15);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", strm.valid_out, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_done", done, 0);
    chk("t4_rst_act_en", act_rd_en, 0);
    chk("t4_rst_wgt_en", wgt_rd_en, 0);
    chk("t4_rst_data", strm.input_data, 0);
    chk("t4_rst_weight", strm.weight_data, 0);
    chk("t4_rst_lt", strm.last_tap, 0);
    chk("t4_rst_lw", strm.last_window, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t4_no_done", done_cnt, 0);
    chk("t4_idle_after_rst", busy, 0);
    clear_mon();
    pulse_start();
    run_pass(0, 2000, fin);
    chk("t4_done_seen", fin, 1);
    repeat (3) tick();
    check_beats("t4");
    chk("t4_done_cnt", done_cnt, 1);

    // start pulses while busy are ignored
    clear_mon();
    pulse_start();
    repeat (3) tick();
    pulse_start();
    repeat (5) tick();
    pulse_start();
    run_pass(0, 2000, fin);
    chk("t5_done_seen", fin, 1);
    repeat (20) tick();
    check_beats("t5");
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_busy_end", busy, 0);
    chk("t5_valid_end", strm.valid_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
